// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped responder beside dmem. Provides a store-to-stream
// TX FIFO, a status/control register and a free-running 32-bit cycle timer.
// Register map (offset DataAdr[3:2]): 0 TXDATA, 1 STATUS, 2 TIMER, 3 reserved.
module mmio_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0200,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        hit,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_STATUS = 2'd1,
        REG_TIMER  = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [4:0]    count_ext;
    logic          ovf;
    logic          valid_q;
    logic [31:0]   timer;

    reg_sel_e      sel;
    logic          wr_hit;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic          empty;
    logic          ovf_clr;
    logic          timer_load;
    logic          unused_addr_bits;

    // Byte-lane bits carry no meaning on this word-only interface.
    assign unused_addr_bits = ^DataAdr[1:0];

    assign sel        = reg_sel_e'(DataAdr[3:2]);
    assign hit        = (DataAdr[31:4] == BASE_ADDR[31:4]);
    assign wr_hit     = MemWrite && hit;
    assign empty      = (count == '0);
    assign full       = (count == DEPTH_C);
    assign push_req   = wr_hit && (sel == REG_TXDATA);
    // Acceptance uses the pre-edge count: a pop on the same edge does not free a slot.
    assign push_ok    = push_req && !full;
    assign pop        = valid_q && out_ready;
    assign ovf_clr    = wr_hit && (sel == REG_STATUS) && WriteData[2];
    assign timer_load = wr_hit && (sel == REG_TIMER);
    assign count_next = count + CW'(push_ok) - CW'(pop);
    assign count_ext  = 5'(count);

    assign out_valid  = valid_q;
    // Head is masked while empty so stale storage never leaks onto the stream.
    assign out_data   = valid_q ? mem[rd_ptr] : '0;

    // FIFO storage write on accepted push.
    // NOTE: the data array has no reset; every entry is written before out_valid can expose it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= WriteData;
        end
    end

    // FIFO pointers, occupancy, registered valid and sticky overflow flag.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_next;
            valid_q <= (count_next != '0);
            // Set has priority over a same-edge clear.
            if (push_req && full) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    // Free-running cycle timer; a store loads it in place of the increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (timer_load) begin
            timer <= WriteData;
        end else begin
            timer <= timer + 32'd1;
        end
    end

    // Combinational load data; reads have no side effects.
    // NOTE: ReadData is defaulted before the case so no path can infer a latch.
    always_comb begin
        ReadData = '0;
        if (hit) begin
            case (sel)
                REG_STATUS: ReadData = {24'b0, count_ext[3:0], 1'b0, ovf, full, empty};
                REG_TIMER:  ReadData = timer;
                default:    ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed, table-driven bench for mmio_responder.
// Each table row is one clock cycle: inputs are driven just after a rising edge,
// combinational/registered outputs are compared at the following falling edge,
// and the next rising edge commits any store or pop.
module tb_mmio_responder;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic        rdy;
        logic [31:0] exp_rd;
        logic        exp_hit;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        hit;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    mmio_responder #(
        .BASE_ADDR (32'h0000_0200),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .MemWrite (MemWrite),
        .DataAdr  (DataAdr),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .hit      (hit),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                           input logic rdy, input logic [31:0] exp_rd, input logic exp_hit,
                           input logic exp_valid, input logic [31:0] exp_data);
        vec_t v;
        v.we = we; v.adr = adr; v.wdata = wdata; v.rdy = rdy;
        v.exp_rd = exp_rd; v.exp_hit = exp_hit; v.exp_valid = exp_valid; v.exp_data = exp_data;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                         input logic rdy);
        MemWrite  = we;
        DataAdr   = adr;
        WriteData = wdata;
        out_ready = rdy;
    endtask

    // Watchdog: the bench has no open-ended waits, but never let it hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ------------------------------------------------------------------
        // Stimulus table (one row per cycle; expectations are pre-edge values)
        // we  adr           wdata         rdy  exp_rd        hit  valid data
        // ------------------------------------------------------------------
        // Fill to full, overflow, drain, clear ovf
        add_vec(1, 32'h200, 32'h11, 0, 32'h00, 1, 0, 32'h00);
        add_vec(1, 32'h200, 32'h22, 0, 32'h00, 1, 1, 32'h11);
        add_vec(1, 32'h200, 32'h33, 0, 32'h00, 1, 1, 32'h11);
        add_vec(1, 32'h200, 32'h44, 0, 32'h00, 1, 1, 32'h11);
        add_vec(0, 32'h204, 32'h00, 0, 32'h42, 1, 1, 32'h11);
        add_vec(1, 32'h200, 32'h55, 0, 32'h00, 1, 1, 32'h11);
        add_vec(0, 32'h204, 32'h00, 0, 32'h46, 1, 1, 32'h11);
        add_vec(0, 32'h204, 32'h00, 1, 32'h46, 1, 1, 32'h11);
        add_vec(0, 32'h204, 32'h00, 1, 32'h34, 1, 1, 32'h22);
        add_vec(0, 32'h204, 32'h00, 1, 32'h24, 1, 1, 32'h33);
        add_vec(0, 32'h204, 32'h00, 1, 32'h14, 1, 1, 32'h44);
        add_vec(0, 32'h204, 32'h00, 0, 32'h05, 1, 0, 32'h00);
        add_vec(1, 32'h204, 32'h04, 0, 32'h05, 1, 0, 32'h00);
        add_vec(0, 32'h204, 32'h00, 0, 32'h01, 1, 0, 32'h00);
        // count==1 simultaneous push/pop, then 6 more pairs to wrap pointers
        add_vec(1, 32'h200, 32'h0A, 0, 32'h00, 1, 0, 32'h00);
        add_vec(1, 32'h200, 32'h0B, 1, 32'h00, 1, 1, 32'h0A);
        add_vec(1, 32'h200, 32'hC1, 1, 32'h00, 1, 1, 32'h0B);
        add_vec(1, 32'h200, 32'hC2, 1, 32'h00, 1, 1, 32'hC1);
        add_vec(1, 32'h200, 32'hC3, 1, 32'h00, 1, 1, 32'hC2);
        add_vec(1, 32'h200, 32'hC4, 1, 32'h00, 1, 1, 32'hC3);
        add_vec(1, 32'h200, 32'hC5, 1, 32'h00, 1, 1, 32'hC4);
        add_vec(1, 32'h200, 32'hC6, 1, 32'h00, 1, 1, 32'hC5);
        add_vec(0, 32'h204, 32'h00, 1, 32'h10, 1, 1, 32'hC6);
        add_vec(0, 32'h204, 32'h00, 0, 32'h01, 1, 0, 32'h00);
        // Full FIFO with push and pop on the same edge: push rejected, ovf set
        add_vec(1, 32'h200, 32'hD1, 0, 32'h00, 1, 0, 32'h00);
        add_vec(1, 32'h200, 32'hD2, 0, 32'h00, 1, 1, 32'hD1);
        add_vec(1, 32'h200, 32'hD3, 0, 32'h00, 1, 1, 32'hD1);
        add_vec(1, 32'h200, 32'hD4, 0, 32'h00, 1, 1, 32'hD1);
        add_vec(1, 32'h200, 32'hD5, 1, 32'h00, 1, 1, 32'hD1);
        add_vec(0, 32'h204, 32'h00, 0, 32'h34, 1, 1, 32'hD2);
        add_vec(1, 32'h204, 32'h04, 1, 32'h34, 1, 1, 32'hD2);
        add_vec(0, 32'h204, 32'h00, 1, 32'h20, 1, 1, 32'hD3);
        add_vec(0, 32'h204, 32'h00, 1, 32'h10, 1, 1, 32'hD4);
        add_vec(0, 32'h204, 32'h00, 0, 32'h01, 1, 0, 32'h00);
        // Window decode, reserved offset, ignored byte-lane bits
        add_vec(1, 32'h0FC, 32'h99, 0, 32'h00, 0, 0, 32'h00);
        add_vec(1, 32'h20C, 32'h99, 0, 32'h00, 1, 0, 32'h00);
        add_vec(0, 32'h20C, 32'h00, 0, 32'h00, 1, 0, 32'h00);
        add_vec(0, 32'h204, 32'h00, 0, 32'h01, 1, 0, 32'h00);
        add_vec(0, 32'h210, 32'h00, 0, 32'h00, 0, 0, 32'h00);
        add_vec(0, 32'h1F4, 32'h00, 0, 32'h00, 0, 0, 32'h00);
        add_vec(0, 32'h206, 32'h00, 0, 32'h01, 1, 0, 32'h00);

        // ---------------- Reset state and timer start ----------------
        reset_n = 1'b0;
        drive(0, 32'h208, 32'h0, 0);
        #12;
        check("reset timer", ReadData, 32'h0);
        check("reset hit", {31'b0, hit}, 32'h1);
        DataAdr = 32'h204;
        #1;
        check("reset status", ReadData, 32'h1);
        check("reset out_valid", {31'b0, out_valid}, 32'h0);
        check("reset out_data", out_data, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        DataAdr = 32'h208;
        @(negedge clk);
        check("timer t0", ReadData, 32'h0);
        @(negedge clk);
        check("timer t1", ReadData, 32'h1);
        @(negedge clk);
        check("timer t2", ReadData, 32'h2);

        // ---------------- Table-driven FIFO / register vectors ----------------
        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].we, vecs[i].adr, vecs[i].wdata, vecs[i].rdy);
            @(negedge clk);
            check($sformatf("v%0d ReadData", i), ReadData, vecs[i].exp_rd);
            check($sformatf("v%0d hit", i), {31'b0, hit}, {31'b0, vecs[i].exp_hit});
            check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("v%0d out_data", i), out_data, vecs[i].exp_data);
            @(posedge clk); #1;
        end

        // ---------------- Timer load and wrap ----------------
        drive(1, 32'h208, 32'hFFFF_FFFE, 0);
        @(posedge clk); #1;
        drive(0, 32'h208, 32'h0, 0);
        @(negedge clk);
        check("timer load", ReadData, 32'hFFFF_FFFE);
        @(negedge clk);
        check("timer load+1", ReadData, 32'hFFFF_FFFF);
        @(negedge clk);
        check("timer wrap", ReadData, 32'h0000_0000);
        @(negedge clk);
        check("timer wrap+1", ReadData, 32'h0000_0001);

        // ---------------- Asynchronous reset mid-drain ----------------
        @(posedge clk); #1;
        drive(1, 32'h200, 32'hE1, 0);
        @(posedge clk); #1;
        drive(1, 32'h200, 32'hE2, 0);
        @(posedge clk); #1;
        drive(1, 32'h200, 32'hE3, 0);
        @(posedge clk); #1;
        drive(0, 32'h204, 32'h0, 1);
        @(negedge clk);
        check("pre-reset status", ReadData, 32'h30);
        check("pre-reset head", out_data, 32'hE1);
        @(posedge clk); #2;
        check("mid-drain head", out_data, 32'hE2);
        reset_n = 1'b0;
        #1;
        check("async rst out_valid", {31'b0, out_valid}, 32'h0);
        check("async rst out_data", out_data, 32'h0);
        check("async rst status", ReadData, 32'h1);
        DataAdr = 32'h208;
        #1;
        check("async rst timer", ReadData, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        drive(0, 32'h204, 32'h0, 0);
        @(negedge clk);
        check("post-reset status", ReadData, 32'h1);
        check("post-reset out_valid", {31'b0, out_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
